// File: rtl/memory_dp_clr.sv
// rtl/memory_dp_clr.sv - dual-port byte-lane memory with registered read and clear sweep
// Separate read/write ports; a clear sequencer fills the array with CLR_VAL after reset or on clr_req.
module memory_dp_clr #(
   parameter int              WIDTH    = 8,
   parameter int              DEPTH    = 6,
   parameter int              LANE_W   = 8,
   parameter int              RDW_MODE = 0,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_req,
   output logic                      busy,
   input  logic                      wr_en,
   input  logic [DEPTH-1:0]          wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [WIDTH/LANE_W-1:0]   wr_be,
   input  logic                      rd_en,
   input  logic [DEPTH-1:0]          rd_addr,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_valid
);

   localparam int NLANES = WIDTH / LANE_W;
   localparam int NWORDS = 2 ** DEPTH;

   typedef enum logic {S_CLR, S_IDLE} state_t;

   state_t           state, state_nxt;
   logic [DEPTH-1:0] clr_cnt, clr_cnt_nxt;
   logic [WIDTH-1:0] mem [NWORDS];
   logic [WIDTH-1:0] wr_merged;
   logic [WIDTH-1:0] rd_word;
   logic             idle;
   logic             clr_last;
   logic             do_wr;
   logic             do_rd;

   assign idle     = (state == S_IDLE);
   assign busy     = !idle;
   assign clr_last = (clr_cnt == {DEPTH{1'b1}});
   assign do_wr    = idle && wr_en && (|wr_be);
   assign do_rd    = idle && rd_en;

   // Merged word is shared by the array write and the write-first read bypass.
   always_comb begin
      wr_merged = mem[wr_addr];
      for (int i = 0; i < NLANES; i++) begin
         if (wr_be[i]) begin
            wr_merged[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
         end
      end
   end

   always_comb begin
      rd_word = mem[rd_addr];
      if ((RDW_MODE != 0) && do_wr && (wr_addr == rd_addr)) begin
         rd_word = wr_merged;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_CLR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // Terminal compare on the last address ends the sweep; the counter is never used past it.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         S_CLR: begin
            clr_cnt_nxt = clr_cnt + DEPTH'(1);
            if (clr_last) begin
               state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (clr_req) begin
               state_nxt   = S_CLR;
               clr_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt   = S_CLR;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == S_CLR) begin
         mem[clr_cnt] <= CLR_VAL;
      end else if (do_wr) begin
         mem[wr_addr] <= wr_merged;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= do_rd;
         if (do_rd) begin
            rd_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_memory_dp_clr.sv
// tb/tb_memory_dp_clr.sv - self-checking bench for memory_dp_clr, both read-during-write modes
module tb_memory_dp_clr;

   localparam logic [15:0] CLRV = 16'hA5A5;

   logic        clk;
   logic        rst;
   logic        clr_req;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic        busy0, busy1;
   logic [15:0] rd_data0, rd_data1;
   logic        rd_valid0, rd_valid1;

   int n_vec = 0;
   int n_err = 0;
   logic cmp_en = 1'b0;

   memory_dp_clr #(.WIDTH(16), .DEPTH(6), .LANE_W(8), .RDW_MODE(0), .CLR_VAL(CLRV)) u_rdw0 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
   );

   memory_dp_clr #(.WIDTH(16), .DEPTH(6), .LANE_W(8), .RDW_MODE(1), .CLR_VAL(CLRV)) u_rdw1 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: words remaining in the sweep, plus an array of expected contents.
   logic [15:0] m_mem [64];
   int          sweep_left = 64;
   logic        m_valid = 1'b0;
   logic [15:0] m_rd0 = 16'h0;
   logic [15:0] m_rd1 = 16'h0;
   logic [15:0] m_old, m_mask, m_merged;

   task model_step();
      if (!rst) begin
         sweep_left = 64;
         m_valid    = 1'b0;
         m_rd0      = 16'h0;
         m_rd1      = 16'h0;
      end else if (sweep_left > 0) begin
         m_mem[64 - sweep_left] = CLRV;
         sweep_left = sweep_left - 1;
         m_valid    = 1'b0;
      end else begin
         m_old    = m_mem[rd_addr];
         m_mask   = {{8{wr_be[1]}}, {8{wr_be[0]}}};
         m_merged = (m_mem[wr_addr] & ~m_mask) | (wr_data & m_mask);
         m_valid  = rd_en;
         if (rd_en) begin
            m_rd0 = m_old;
            m_rd1 = (wr_en && wr_addr == rd_addr) ? m_merged : m_old;
         end
         if (wr_en) m_mem[wr_addr] = m_merged;
         if (clr_req) sweep_left = 64;
      end
   endtask

   always @(posedge clk or negedge rst) model_step();

   task check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task compare_all();
      check("busy0",     {15'h0, busy0},     {15'h0, sweep_left > 0});
      check("busy1",     {15'h0, busy1},     {15'h0, sweep_left > 0});
      check("rd_valid0", {15'h0, rd_valid0}, {15'h0, m_valid});
      check("rd_valid1", {15'h0, rd_valid1}, {15'h0, m_valid});
      check("rd_data0",  rd_data0, m_rd0);
      check("rd_data1",  rd_data1, m_rd1);
   endtask

   always @(negedge clk) if (cmp_en) compare_all();

   task idle_inputs();
      clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_be = 2'b00;
   endtask

   task do_write(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      @(negedge clk);
      wr_en = 1'b0; wr_be = 2'b00;
   endtask

   task do_read(input string name, input logic [5:0] a, input logic [15:0] e0, input logic [15:0] e1);
      rd_en = 1'b1; rd_addr = a;
      @(negedge clk);
      rd_en = 1'b0;
      check({name, "_valid"}, {15'h0, rd_valid0 & rd_valid1}, 16'h0001);
      check({name, "_m0"}, rd_data0, e0);
      check({name, "_m1"}, rd_data1, e1);
   endtask

   // Counts sampled cycles with busy high, starting at the current negedge.
   task count_busy(output int n);
      n = 0;
      for (int k = 0; k < 300; k++) begin
         if (!busy0) break;
         n = n + 1;
         @(negedge clk);
      end
   endtask

   int nb;

   initial begin
      rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      wr_be = 2'b00; rd_en = 1'b0; rd_addr = '0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("reset_busy", {15'h0, busy0}, 16'h0001);
      check("reset_rd_data", rd_data0, 16'h0000);

      // Power-up sweep and reads of cleared words
      rst = 1'b1;
      count_busy(nb);
      check("sweep_len_reset", nb[15:0], 16'd64);
      do_read("t1_a0",  6'd0,  CLRV, CLRV);
      do_read("t1_a31", 6'd31, CLRV, CLRV);
      do_read("t1_a63", 6'd63, CLRV, CLRV);

      // Byte-lane writes
      do_write(6'd5, 16'h1234, 2'b11);
      do_write(6'd5, 16'hFF00, 2'b01);
      do_read("t2_lane", 6'd5, 16'h1200, 16'h1200);
      do_write(6'd5, 16'hFFFF, 2'b00);
      do_read("t2_be0", 6'd5, 16'h1200, 16'h1200);

      // Same-address read-during-write
      do_write(6'd9, 16'h0001, 2'b11);
      wr_en = 1'b1; wr_addr = 6'd9; wr_data = 16'hBEEF; wr_be = 2'b11;
      do_read("t3_rdw", 6'd9, 16'h0001, 16'hBEEF);
      wr_en = 1'b0; wr_be = 2'b00;
      do_read("t3_after", 6'd9, 16'hBEEF, 16'hBEEF);

      // Clear request alongside a write; traffic during busy must be ignored
      clr_req = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 16'h7777; wr_be = 2'b11;
      @(negedge clk);
      check("t4_busy_rise", {15'h0, busy0}, 16'h0001);
      clr_req = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_addr = 6'd10; rd_addr = 6'd10;
      wr_data = 16'h5555; wr_be = 2'b11;
      count_busy(nb);
      idle_inputs();
      check("sweep_len_req", nb[15:0], 16'd64);
      do_read("t4_a3",  6'd3,  CLRV, CLRV);
      do_read("t4_a10", 6'd10, CLRV, CLRV);

      // Asynchronous reset in the middle of a sweep
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("t5_rd_data0", rd_data0, 16'h0000);
      check("t5_rd_data1", rd_data1, 16'h0000);
      check("t5_rd_valid", {15'h0, rd_valid0 | rd_valid1}, 16'h0000);
      check("t5_busy", {15'h0, busy0 & busy1}, 16'h0001);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      count_busy(nb);
      check("sweep_len_rst", nb[15:0], 16'd64);

      // Back-to-back reads after filling addresses 0..7 with i*3
      for (int i = 0; i < 8; i++) do_write(6'(i), 16'(i * 3), 2'b11);
      rd_en = 1'b1; rd_addr = 6'd0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("t6_valid", {15'h0, rd_valid0 & rd_valid1}, 16'h0001);
         check("t6_data0", rd_data0, 16'((i - 1) * 3));
         check("t6_data1", rd_data1, 16'((i - 1) * 3));
         if (i < 8) rd_addr = 6'(i);
         else       rd_en = 1'b0;
      end
      @(negedge clk);
      check("t6_valid_drop", {15'h0, rd_valid0 | rd_valid1}, 16'h0000);
      check("t6_hold", rd_data0, 16'd21);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
